// File: rtl/onchip_mem_read_master_if.sv
// Bus bundle for the on-chip RAM read master: Avalon-MM read side toward the
// memory slave and the valid/ready stream toward the crypto datapath.
interface onchip_mem_read_master_if #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   avm_address;
    logic                avm_chipselect;
    logic                avm_write;
    logic [DATA_W/8-1:0] avm_byteenable;
    logic                avm_clken;
    logic [DATA_W-1:0]   avm_readdata;
    logic [DATA_W-1:0]   src_data;
    logic                src_valid;
    logic                src_last;
    logic                src_ready;

    modport master (
        output avm_address, avm_chipselect, avm_write, avm_byteenable, avm_clken,
        input  avm_readdata,
        output src_data, src_valid, src_last,
        input  src_ready
    );

    modport slave (
        input  avm_address, avm_chipselect, avm_write, avm_byteenable, avm_clken,
        output avm_readdata,
        input  src_data, src_valid, src_last,
        output src_ready
    );
endinterface

// File: rtl/onchip_mem_read_master.sv
// Avalon-MM read master: fetches word_count consecutive words from on-chip RAM
// and streams them in address order through a small credit-protected FIFO.
module onchip_mem_read_master #(
    parameter int ADDR_W       = 11,
    parameter int DATA_W       = 32,
    parameter int READ_LATENCY = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start_i,
    input  logic [ADDR_W-1:0]    base_addr_i,
    input  logic [ADDR_W:0]      word_count_i,
    output logic                 busy_o,
    output logic                 done_o,
    onchip_mem_read_master_if.master bus
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [PTR_W-1:0]  PTR_ZERO  = {PTR_W{1'b0}};
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
    localparam logic [ADDR_W:0]   WCNT_ONE  = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W:0]   WCNT_ZERO = {(ADDR_W + 1){1'b0}};

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ISSUE  = 2'd1,
        S_DRAIN  = 2'd2,
        S_FINISH = 2'd3
    } state_e;

    state_e                   state_q, state_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;
    logic                     cs_q, cs_d;
    logic [ADDR_W-1:0]        addr_q, addr_d;
    logic [ADDR_W-1:0]        next_addr_q, next_addr_d;
    logic [ADDR_W:0]          rem_q, rem_d;
    logic [ADDR_W:0]          cnt_q, cnt_d;
    logic [ADDR_W:0]          pcnt_q, pcnt_d;
    logic [READ_LATENCY-1:0]  vld_q, vld_d;
    logic [CNT_W-1:0]         occ_q, occ_d;
    logic [CNT_W-1:0]         fcnt_q, fcnt_d;
    logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]         rd_ptr_q, rd_ptr_d;
    logic [DATA_W:0]          fifo_q [FIFO_DEPTH];

    logic                     pop_s;
    logic                     push_s;
    logic                     push_last_s;
    logic                     head_last_s;
    logic                     credit_s;
    logic                     issue_s;
    logic                     accept_s;

    // occ_q counts FIFO entries plus reads still in the memory pipeline, so a
    // read is only launched when its data is guaranteed a slot on arrival.
    assign pop_s       = (fcnt_q != CNT_ZERO) & bus.src_ready;
    assign push_s      = vld_q[READ_LATENCY-1];
    assign push_last_s = (pcnt_q == (cnt_q - WCNT_ONE));
    assign head_last_s = fifo_q[rd_ptr_q][DATA_W];
    assign credit_s    = (occ_q < DEPTH_C) | pop_s;
    assign accept_s    = start_i & ~done_q;

    // Command FSM: next state, read issue and address/count bookkeeping.
    always_comb begin
        state_d     = state_q;
        cs_d        = 1'b0;
        issue_s     = 1'b0;
        addr_d      = addr_q;
        next_addr_d = next_addr_q;
        rem_d       = rem_q;
        cnt_d       = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (accept_s) begin
                    cnt_d       = word_count_i;
                    rem_d       = word_count_i;
                    next_addr_d = base_addr_i;
                    if (word_count_i == WCNT_ZERO) begin
                        state_d = S_FINISH;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ISSUE: begin
                if (credit_s) begin
                    issue_s     = 1'b1;
                    cs_d        = 1'b1;
                    addr_d      = next_addr_q;
                    next_addr_d = next_addr_q + ADDR_ONE;
                    rem_d       = rem_q - WCNT_ONE;
                    if (rem_q == WCNT_ONE) begin
                        state_d = S_DRAIN;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end else begin
                    state_d = S_ISSUE;
                end
            end
            S_DRAIN: begin
                // The last word leaving the FIFO implies every earlier read landed.
                if (pop_s && head_last_s) begin
                    state_d = S_FINISH;
                end else begin
                    state_d = S_DRAIN;
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
        done_d = (state_q == S_FINISH);
    end

    // Read-capture pipeline and FIFO pointer/count bookkeeping.
    always_comb begin
        vld_d[0] = cs_q;
        for (int i = 1; i < READ_LATENCY; i++) begin
            vld_d[i] = vld_q[i-1];
        end
        occ_d    = occ_q + CNT_W'(issue_s) - CNT_W'(pop_s);
        fcnt_d   = fcnt_q + CNT_W'(push_s) - CNT_W'(pop_s);
        wr_ptr_d = wr_ptr_q + PTR_W'(push_s);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop_s);
        if ((state_q == S_IDLE) && accept_s) begin
            pcnt_d = WCNT_ZERO;
        end else if (push_s) begin
            pcnt_d = pcnt_q + WCNT_ONE;
        end else begin
            pcnt_d = pcnt_q;
        end
    end

    // State and control registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            cs_q        <= 1'b0;
            addr_q      <= ADDR_ZERO;
            next_addr_q <= ADDR_ZERO;
            rem_q       <= WCNT_ZERO;
            cnt_q       <= WCNT_ZERO;
            pcnt_q      <= WCNT_ZERO;
            vld_q       <= {READ_LATENCY{1'b0}};
            occ_q       <= CNT_ZERO;
            fcnt_q      <= CNT_ZERO;
            wr_ptr_q    <= PTR_ZERO;
            rd_ptr_q    <= PTR_ZERO;
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            cs_q        <= cs_d;
            addr_q      <= addr_d;
            next_addr_q <= next_addr_d;
            rem_q       <= rem_d;
            cnt_q       <= cnt_d;
            pcnt_q      <= pcnt_d;
            vld_q       <= vld_d;
            occ_q       <= occ_d;
            fcnt_q      <= fcnt_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
        end
    end

    // FIFO storage; entries are qualified by fcnt_q so no reset is needed.
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_q[wr_ptr_q] <= {push_last_s, bus.avm_readdata};
        end
    end

    assign busy_o             = busy_q;
    assign done_o             = done_q;
    assign bus.avm_address    = addr_q;
    assign bus.avm_chipselect = cs_q;
    assign bus.avm_write      = 1'b0;
    assign bus.avm_byteenable = {(DATA_W/8){1'b1}};
    assign bus.avm_clken      = 1'b1;
    assign bus.src_data       = fifo_q[rd_ptr_q][DATA_W-1:0];
    assign bus.src_valid      = (fcnt_q != CNT_ZERO);
    assign bus.src_last       = (fcnt_q != CNT_ZERO) & head_last_s;
endmodule

// File: tb/tb_onchip_mem_read_master.sv
// Directed and randomized bench for onchip_mem_read_master with a 1-cycle RAM
// model and a queue-based reference of expected addresses and stream words.
module tb_onchip_mem_read_master;
    localparam int AW    = 11;
    localparam int DW    = 32;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          start;
    logic [AW-1:0] base;
    logic [AW:0]   cnt;
    logic          busy;
    logic          done;

    always #5 clk = ~clk;

    onchip_mem_read_master_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    onchip_mem_read_master #(
        .ADDR_W(AW), .DATA_W(DW), .READ_LATENCY(1), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start_i      (start),
        .base_addr_i  (base),
        .word_count_i (cnt),
        .busy_o       (busy),
        .done_o       (done),
        .bus          (bus)
    );

    logic [DW-1:0] mem [0:2047];

    always @(posedge clk) begin
        if (bus.avm_chipselect === 1'b1) bus.avm_readdata <= mem[bus.avm_address];
    end

    int            checks = 0;
    int            errors = 0;
    logic [DW:0]   exp_q[$];
    logic [AW-1:0] exp_addr_q[$];
    int            issued, accepted, done_cnt, cyc, first_acc, last_acc;
    bit            start_pend = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic bit pick_ready(input int mode);
        if (mode == 0) return 1'b1;
        if (mode == 1) return cyc[0];
        return ($urandom_range(0, 3) != 0);
    endfunction

    // One clock: drive inputs at the falling edge, then observe this cycle's outputs.
    task automatic cycle(input bit rdy);
        logic [DW:0] e;
        @(negedge clk);
        cyc++;
        bus.src_ready = rdy;
        start         = start_pend;
        start_pend    = 1'b0;
        if (bus.avm_chipselect === 1'b1) begin
            issued++;
            if (exp_addr_q.size() == 0) chk("cs_unexpected", 64'd1, 64'd0);
            else chk("cs_addr", 64'(bus.avm_address), 64'(exp_addr_q.pop_front()));
            chk("credit", 64'(issued - accepted <= DEPTH), 64'd1);
        end
        if (bus.src_valid === 1'b1 && rdy) begin
            accepted++;
            if (first_acc < 0) first_acc = cyc;
            last_acc = cyc;
            if (exp_q.size() == 0) chk("valid_unexpected", 64'd1, 64'd0);
            else begin
                e = exp_q.pop_front();
                chk("data", 64'(bus.src_data), 64'(e[DW-1:0]));
                chk("last", 64'(bus.src_last), 64'(e[DW]));
            end
        end
        if (done === 1'b1) done_cnt++;
    endtask

    task automatic issue_cmd(input logic [AW-1:0] b, input logic [AW:0] n, input bit fresh);
        logic [AW-1:0] a;
        base       = b;
        cnt        = n;
        start_pend = 1'b1;
        if (fresh) begin
            issued = 0; accepted = 0; done_cnt = 0; first_acc = -1;
            for (int i = 0; i < int'(n); i++) begin
                a = b + AW'(i);
                exp_addr_q.push_back(a);
                exp_q.push_back({(i == int'(n) - 1), mem[a]});
            end
        end
    endtask

    task automatic run_wait(input string tag, input int mode, input int limit, input int words);
        int n = 0;
        while (done_cnt == 0 && n < limit) begin
            cycle(pick_ready(mode));
            n++;
        end
        chk({tag, "_timeout"}, 64'(done_cnt), 64'd1);
        chk({tag, "_busy_at_done"}, 64'(busy), 64'd0);
        chk({tag, "_words"}, 64'(accepted), 64'(words));
        chk({tag, "_left"}, 64'(exp_q.size() + exp_addr_q.size()), 64'd0);
        for (int i = 0; i < 3; i++) cycle(1'b1);
        chk({tag, "_done_once"}, 64'(done_cnt), 64'd1);
    endtask

    initial begin
        logic [AW-1:0] rb;
        logic [AW:0]   rn;
        int            n;
        cyc = 0; issued = 0; accepted = 0; done_cnt = 0; first_acc = -1; last_acc = 0;
        start = 1'b0; base = '0; cnt = '0; bus.src_ready = 1'b0;
        for (int i = 0; i < 2048; i++) mem[i] = $urandom;
        reset_n = 1'b1;
        #2 reset_n = 1'b0;
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_cs", 64'(bus.avm_chipselect), 64'd0);
        chk("rst_valid", 64'(bus.src_valid), 64'd0);
        chk("rst_last", 64'(bus.src_last), 64'd0);
        chk("rst_addr", 64'(bus.avm_address), 64'd0);
        chk("const_write", 64'(bus.avm_write), 64'd0);
        chk("const_be", 64'(bus.avm_byteenable), 64'hF);
        chk("const_clken", 64'(bus.avm_clken), 64'd1);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;

        // T1: known pattern, sink always ready, words on consecutive cycles
        for (int i = 0; i < 8; i++) mem[16 + i] = 32'hA0 + 32'(i);
        issue_cmd(11'h010, 12'd8, 1'b1);
        run_wait("t1", 0, 200, 8);
        chk("t1_back_to_back", 64'(last_acc - first_acc), 64'd7);

        // T2: toggling backpressure
        issue_cmd(11'h010, 12'd8, 1'b1);
        run_wait("t2", 1, 200, 8);

        // T3: address wrap at the top of memory
        issue_cmd(11'h7FE, 12'd4, 1'b1);
        run_wait("t3", 2, 200, 4);

        // T4: zero-length command, then whole memory
        issue_cmd(11'h005, 12'd0, 1'b1);
        cycle(1'b1);
        cycle(1'b1);
        chk("t4_busy", 64'(busy), 64'd1);
        chk("t4_done_early", 64'(done), 64'd0);
        cycle(1'b1);
        chk("t4_done", 64'(done), 64'd1);
        chk("t4_busy_clear", 64'(busy), 64'd0);
        for (int i = 0; i < 3; i++) cycle(1'b1);
        chk("t4_done_once", 64'(done_cnt), 64'd1);
        chk("t4_no_words", 64'(issued + accepted), 64'd0);
        rb = AW'($urandom_range(0, 2047));
        issue_cmd(rb, 12'd2048, 1'b1);
        run_wait("t4_full", 0, 3000, 2048);

        // T5: start while busy is ignored
        issue_cmd(11'h020, 12'd8, 1'b1);
        for (int i = 0; i < 3; i++) cycle(pick_ready(1));
        issue_cmd(11'h100, 12'd5, 1'b0);
        run_wait("t5", 1, 200, 8);

        // T6: reset in the middle of a command
        issue_cmd(11'h040, 12'd8, 1'b1);
        n = 0;
        while (accepted < 3 && n < 50) begin
            cycle(1'b1);
            n++;
        end
        chk("t6_three_words", 64'(accepted), 64'd3);
        @(posedge clk);
        #1 reset_n = 1'b0;
        #1;
        chk("t6_valid", 64'(bus.src_valid), 64'd0);
        chk("t6_cs", 64'(bus.avm_chipselect), 64'd0);
        chk("t6_busy", 64'(busy), 64'd0);
        chk("t6_last", 64'(bus.src_last), 64'd0);
        chk("t6_addr", 64'(bus.avm_address), 64'd0);
        chk("t6_no_done", 64'(done_cnt), 64'd0);
        exp_q.delete();
        exp_addr_q.delete();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) cycle(1'b1);

        // Randomized commands after reset
        for (int k = 0; k < 8; k++) begin
            rb = AW'($urandom_range(0, 2047));
            rn = (AW + 1)'($urandom_range(1, 40));
            issue_cmd(rb, rn, 1'b1);
            run_wait("rand", 2, 600, int'(rn));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
